// File: rtl/output_stream_pkg.sv
// Shared types and sizing helpers for the output stream reader.
package output_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEFAULT_FIFO_DEPTH = 4;
  localparam int DEFAULT_ADD_SIZE   = 11;

  // Counters carry one extra bit so a full 2^ADD_SIZE transfer is representable.
  function automatic int cnt_w(input int add_size);
    return add_size + 1;
  endfunction

endpackage

// File: rtl/output_stream_reader_fifo.sv
// Small synchronous FIFO with occupancy count and same-cycle push/pop.
module stream_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [DW-1:0]            i_data,
  input  logic                     i_pop,
  output logic [DW-1:0]            o_data,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_pop  = i_pop && (r_count != (AW+1)'(0));
  assign w_do_push = i_push && ((r_count != L_FULL) || w_do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_count  <= (AW+1)'(0);
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= DW'(0);
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/output_stream_reader.sv
// Drains a contiguous range of the output RAM into a valid/ready stream with a last marker.
module output_stream_reader
  import output_stream_pkg::*;
#(
  parameter int ADD_SIZE   = DEFAULT_ADD_SIZE,
  parameter int DATA_SIZE  = 32,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADD_SIZE-1:0]  base_addr,
  input  logic [ADD_SIZE:0]    word_count,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_read_en,
  output logic [ADD_SIZE-1:0]  mem_read_address,
  output logic                 mem_in_ready,
  input  logic [DATA_SIZE-1:0] mem_dataIn,
  input  logic                 mem_out_valid,
  output logic [DATA_SIZE-1:0] m_data,
  output logic                 m_valid,
  output logic                 m_last,
  input  logic                 m_ready
);
  localparam int CNT_W = cnt_w(ADD_SIZE);
  localparam int OW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [OW:0] L_DEPTH = (OW+1)'(FIFO_DEPTH);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ADD_SIZE-1:0]  r_base;
  logic [CNT_W-1:0]     r_count;
  logic [CNT_W-1:0]     r_issued;
  logic [CNT_W-1:0]     r_loaded;
  logic [OW-1:0]        r_outstanding;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_in_ready;
  logic                 r_rd_en;
  logic [ADD_SIZE-1:0]  r_rd_addr;
  logic                 r_m_valid;
  logic                 r_m_last;
  logic [DATA_SIZE-1:0] r_m_data;

  logic                 w_busy_nxt;
  logic                 w_done_nxt;
  logic                 w_accept;
  logic                 w_take;
  logic                 w_ret;
  logic                 w_fifo_pop;
  logic                 w_fifo_push;
  logic                 w_bypass;
  logic                 w_load;
  logic [DATA_SIZE-1:0] w_load_data;
  logic [DATA_SIZE-1:0] w_fifo_data;
  logic [OW-1:0]        w_fifo_count;
  logic [OW:0]          w_pool;
  logic                 w_credit;
  logic                 w_issue;
  logic                 w_last_issue;
  logic [ADD_SIZE-1:0]  w_issue_addr;
  logic                 w_final_hs;

  stream_fifo #(
    .DW    (DATA_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_fifo_push),
    .i_data  (mem_dataIn),
    .i_pop   (w_fifo_pop),
    .o_data  (w_fifo_data),
    .o_count (w_fifo_count)
  );

  assign w_accept    = (r_state == IDLE) && start;
  assign w_take      = !r_m_valid || m_ready;
  assign w_ret       = mem_out_valid && (r_outstanding != OW'(0)) &&
                       ((r_state == ISSUE) || (r_state == DRAIN));
  assign w_fifo_pop  = w_take && (w_fifo_count != OW'(0));
  assign w_bypass    = w_take && (w_fifo_count == OW'(0)) && w_ret;
  assign w_load      = w_fifo_pop || w_bypass;
  assign w_fifo_push = w_ret && !w_bypass;
  assign w_load_data = w_fifo_pop ? w_fifo_data : mem_dataIn;

  // Credit pool counts words owed by the RAM plus words parked in the FIFO, after this cycle's move to the output register.
  assign w_pool   = {1'b0, r_outstanding} + {1'b0, w_fifo_count} - (OW+1)'(w_load);
  assign w_credit = w_pool < L_DEPTH;

  assign w_issue      = (w_accept && (word_count != CNT_W'(0))) ||
                        ((r_state == ISSUE) && w_credit && (r_issued != r_count));
  assign w_issue_addr = (r_state == IDLE) ? base_addr : (r_base + r_issued[ADD_SIZE-1:0]);
  assign w_last_issue = (r_state == ISSUE) && w_issue && ((r_issued + CNT_W'(1)) == r_count);
  assign w_final_hs   = r_m_valid && m_ready && r_m_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (!start)                                w_state_nxt = IDLE;
        else if (word_count == CNT_W'(0))          w_state_nxt = DONE;
        else if (word_count == CNT_W'(1))          w_state_nxt = DRAIN;
        else                                       w_state_nxt = ISSUE;
      end
      ISSUE: begin
        if (w_last_issue) w_state_nxt = DRAIN;
        else              w_state_nxt = ISSUE;
      end
      DRAIN: begin
        if (w_final_hs) w_state_nxt = DONE;
        else            w_state_nxt = DRAIN;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    case (w_state_nxt)
      ISSUE, DRAIN: w_busy_nxt = 1'b1;
      DONE:         w_done_nxt = 1'b1;
      default:      w_busy_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_in_ready <= 1'b0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_in_ready <= w_busy_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_base        <= ADD_SIZE'(0);
      r_count       <= CNT_W'(0);
      r_issued      <= CNT_W'(0);
      r_loaded      <= CNT_W'(0);
      r_outstanding <= OW'(0);
      r_rd_en       <= 1'b0;
      r_rd_addr     <= ADD_SIZE'(0);
    end else begin
      if (w_accept) begin
        r_base   <= base_addr;
        r_count  <= word_count;
        r_issued <= CNT_W'(w_issue);
        r_loaded <= CNT_W'(0);
      end else begin
        r_issued <= r_issued + CNT_W'(w_issue);
        r_loaded <= r_loaded + CNT_W'(w_load);
      end
      r_outstanding <= r_outstanding + OW'(w_issue) - OW'(w_ret);
      r_rd_en       <= w_issue;
      if (w_issue) r_rd_addr <= w_issue_addr;
    end
  end

  // Output register holds steady under backpressure; empty FIFO lets a return bypass straight in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_data  <= DATA_SIZE'(0);
    end else if (w_take) begin
      if (w_load) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_load_data;
        r_m_last  <= (r_loaded == (r_count - CNT_W'(1)));
      end else begin
        r_m_valid <= 1'b0;
        r_m_last  <= 1'b0;
      end
    end
  end

  assign busy             = r_busy;
  assign done             = r_done;
  assign mem_in_ready     = r_in_ready;
  assign mem_read_en      = r_rd_en;
  assign mem_read_address = r_rd_addr;
  assign m_valid          = r_m_valid;
  assign m_last           = r_m_last;
  assign m_data           = r_m_data;

endmodule

// File: tb/tb_output_stream_reader.sv
// Scoreboard bench: a RAM/wrapper model feeds the DUT, a reference model predicts addresses and stream words.
module tb_output_stream_reader;
  localparam int AW = 11;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   word_count = '0;
  logic          busy, done, mem_read_en, mem_in_ready, m_valid, m_last;
  logic [AW-1:0] mem_read_address;
  logic [DW-1:0] mem_dataIn = '0;
  logic          mem_out_valid = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b1;

  output_stream_reader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .busy(busy), .done(done), .mem_read_en(mem_read_en), .mem_read_address(mem_read_address),
    .mem_in_ready(mem_in_ready), .mem_dataIn(mem_dataIn), .mem_out_valid(mem_out_valid),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [DW-1:0] data; } ret_t;
  typedef struct { logic [DW-1:0] data; bit last; } word_t;

  logic [DW-1:0] mem_img [2048];
  ret_t  pend[$];
  word_t exp_words[$];
  int    exp_addrs[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lat_v = 2;
  int rmode = 0;
  int spur_cnt = 0;
  int first_ret_cyc = -1;
  int exp_done_cyc = -1;
  int done_cyc = -1;
  int start_cyc = 0;
  int hs_count = 0;
  bit xfer_active = 0;
  bit valid_seen = 0;
  bit done_seen = 0;
  bit prev_stall = 0;
  logic [DW-1:0] prev_data = '0;
  logic prev_last = 1'b0;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output RAM wrapper model: fixed-latency returns plus optional spurious valids.
  always @(posedge clk) begin
    ret_t r;
    #1;
    if (rst && mem_read_en) begin
      r.due  = cyc + lat_v;
      r.data = mem_img[mem_read_address];
      pend.push_back(r);
    end
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      r = pend.pop_front();
      mem_out_valid = 1'b1;
      mem_dataIn    = r.data;
      if (xfer_active && first_ret_cyc < 0) first_ret_cyc = cyc;
    end else if (spur_cnt > 0) begin
      spur_cnt--;
      mem_out_valid = 1'b1;
      mem_dataIn    = $urandom;
    end else begin
      mem_out_valid = 1'b0;
      mem_dataIn    = $urandom;
    end
  end

  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       m_ready = 1'b1;
      1:       m_ready = ~m_ready;
      default: m_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: pops the scoreboard whenever the DUT presents a read or a stream handshake.
  always @(negedge clk) begin
    int a;
    word_t w;
    if (!rst) begin
      prev_stall = 0;
    end else begin
      if (mem_read_en) begin
        if (exp_addrs.size() == 0) chk(1'b0, "unexpected_read", mem_read_address, 0);
        else begin
          a = exp_addrs.pop_front();
          chk(mem_read_address == a[AW-1:0], "read_addr", mem_read_address, a);
        end
        chk(busy && mem_in_ready, "busy_inready_on_read", {busy, mem_in_ready}, 3);
      end
      if (prev_stall)
        chk(m_valid && m_data == prev_data && m_last == prev_last, "stall_stable", m_data, prev_data);
      if (m_valid && !valid_seen && first_ret_cyc >= 0) begin
        chk(cyc == first_ret_cyc + 1, "first_valid_latency", cyc, first_ret_cyc + 1);
        valid_seen = 1;
      end
      if (m_last) chk(m_valid, "last_without_valid", m_valid, 1);
      if (m_valid && m_ready) begin
        if (exp_words.size() == 0) chk(1'b0, "unexpected_word", m_data, 0);
        else begin
          w = exp_words.pop_front();
          chk(m_data == w.data, "stream_data", m_data, w.data);
          chk(m_last == w.last, "stream_last", m_last, w.last);
          hs_count++;
          if (w.last) exp_done_cyc = cyc + 1;
        end
      end
      if (done || cyc == exp_done_cyc) begin
        chk(done && cyc == exp_done_cyc && !busy, "done_pulse", {done, busy}, 2);
        if (done) begin
          done_seen = 1;
          done_cyc  = cyc;
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk(busy == 1'b0,             {tag, "_busy"},  busy, 0);
    chk(done == 1'b0,             {tag, "_done"},  done, 0);
    chk(mem_read_en == 1'b0,      {tag, "_rd_en"}, mem_read_en, 0);
    chk(mem_read_address == '0,   {tag, "_addr"},  mem_read_address, 0);
    chk(mem_in_ready == 1'b0,     {tag, "_in_rdy"}, mem_in_ready, 0);
    chk(m_valid == 1'b0,          {tag, "_valid"}, m_valid, 0);
    chk(m_last == 1'b0,           {tag, "_last"},  m_last, 0);
    chk(m_data == '0,             {tag, "_data"},  m_data, 0);
  endtask

  task automatic clear_model();
    exp_words.delete();
    exp_addrs.delete();
    exp_done_cyc = -1;
    xfer_active  = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
    pend.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic start_xfer(input int base, input int count, input int mode, input int lat);
    word_t w;
    for (int i = 0; i < 20 && pend.size() != 0; i++) @(posedge clk);
    @(posedge clk); #1;
    lat_v = lat; rmode = mode;
    first_ret_cyc = -1; valid_seen = 0; done_seen = 0; done_cyc = -1;
    exp_done_cyc = -1; hs_count = 0; xfer_active = 1;
    for (int i = 0; i < count; i++) begin
      exp_addrs.push_back((base + i) % 2048);
      w.data = mem_img[(base + i) % 2048];
      w.last = (i == count - 1);
      exp_words.push_back(w);
    end
    start = 1'b1; base_addr = AW'(base); word_count = (AW+1)'(count);
    start_cyc = cyc;
    if (count == 0) exp_done_cyc = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0; base_addr = $urandom; word_count = $urandom;
    chk(busy == (count != 0), "busy_rise", busy, count != 0);
    chk(mem_read_en == (count != 0), "first_read_en", mem_read_en, count != 0);
  endtask

  task automatic finish_xfer(input int count, input int mode, input int lat);
    for (int i = 0; i < count * 8 + 40 && !done_seen; i++) @(posedge clk);
    chk(done_seen, "transfer_complete", done_seen, 1);
    if (!done_seen) do_reset();
    else begin
      chk(exp_words.size() == 0 && exp_addrs.size() == 0, "all_consumed",
          exp_words.size() + exp_addrs.size(), 0);
      if (mode == 0 && count > 0)
        chk(done_cyc == start_cyc + count + lat + 2, "throughput_done_cycle", done_cyc, start_cyc + count + lat + 2);
    end
    xfer_active = 0;
    exp_done_cyc = -1;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem_img[i] = $urandom;
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("reset");
    @(posedge clk); #1 rst = 1'b1;

    start_xfer(16, 8, 0, 2);    finish_xfer(8, 0, 2);
    start_xfer(16, 8, 1, 2);    finish_xfer(8, 1, 2);
    start_xfer(2046, 4, 0, 3);  finish_xfer(4, 0, 3);
    start_xfer(100, 0, 0, 2);   finish_xfer(0, 0, 2);

    // A second start while issuing must be ignored.
    start_xfer(16, 8, 1, 2);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 11'h300; word_count = 12'd5;
    @(posedge clk); #1;
    start = 1'b0;
    finish_xfer(8, 1, 2);

    // Abort mid-transfer, then feed stale and spurious returns.
    start_xfer(16, 8, 0, 2);
    for (int i = 0; i < 100 && hs_count < 3; i++) @(posedge clk);
    #1;
    chk(hs_count == 3, "abort_point", hs_count, 3);
    rst = 1'b0;
    clear_model();
    #1 chk_reset_outputs("abort");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    spur_cnt = 3;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      chk(!m_valid && !busy && !mem_read_en, "quiet_after_abort", {m_valid, busy, mem_read_en}, 0);
    end
    start_xfer(500, 6, 0, 2);   finish_xfer(6, 0, 2);

    for (int t = 0; t < 12; t++) begin
      int b, c, m, l, r;
      b = $urandom_range(0, 2047);
      r = $urandom_range(0, 9);
      c = (r == 0) ? 0 : (r == 1) ? 1 : $urandom_range(2, 40);
      m = $urandom_range(0, 2);
      l = $urandom_range(1, 3);
      start_xfer(b, c, m, l);
      finish_xfer(c, m, l);
    end

    start_xfer($urandom_range(0, 2047), 2048, 0, 3);
    finish_xfer(2048, 0, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/output_stream_reader.md
# output_stream_reader

Downstream drain stage for the output memory wrapper. On a `start` command it walks a contiguous address range of the output RAM, issuing one read per cycle through the wrapper's read port and accepting returned words on the wrapper's `out_valid`. It buffers returned words in a small credit-controlled FIFO and presents them as a valid/ready stream with a `last` marker to the host-side transfer logic. It sits between the output memory wrapper and the host DMA/stream interface.

## Interface
Parameters:
- `ADD_SIZE`, 11, output RAM address width
- `DATA_SIZE`, 32, word width
- `FIFO_DEPTH`, 4, skid/credit FIFO depth (power of two, ≥2)

Ports:
- `clk`  in  1  single clock; all logic rising-edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle command strobe
- `base_addr`  in  ADD_SIZE  first word address, sampled on accepted `start`
- `word_count`  in  ADD_SIZE+1  words to transfer (0..2^ADD_SIZE), sampled on accepted `start`
- `busy`  out  1  high from accepted `start` until `done`
- `done`  out  1  one-cycle completion pulse
- `mem_read_en`  out  1  read request to wrapper
- `mem_read_address`  out  ADD_SIZE  read address to wrapper
- `mem_in_ready`  out  1  ready to wrapper read controller
- `mem_dataIn`  in  DATA_SIZE  read data from wrapper
- `mem_out_valid`  in  1  read data valid from wrapper
- `m_data`  out  DATA_SIZE  stream data
- `m_valid`  out  1  stream valid
- `m_last`  out  1  marks final word of transfer
- `m_ready`  in  1  stream consumer ready

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: `start`=1 latches `base_addr`, `word_count`, and clears the issue counter → ISSUE; if `word_count`=0 → DONE directly (no reads).
- ISSUE: asserts `mem_read_en` with `mem_read_address` = `base_addr` + issued (mod 2^ADD_SIZE; wraps 2^ADD_SIZE−1 → 0) when credit is available, i.e. outstanding + fifo_count < FIFO_DEPTH. After the last read is issued → DRAIN.
- DRAIN: no reads. When the final word has been handshaken on `m_valid`&`m_ready` → DONE.
- DONE: `done`=1 for one cycle, `busy`=0 → IDLE.
- `start` outside IDLE is ignored.
- `mem_in_ready`=1 in ISSUE and DRAIN. The credit rule guarantees the FIFO never overflows.
- A return on `mem_out_valid` pushes `mem_dataIn` into the FIFO and decrements outstanding. A `mem_out_valid` with outstanding=0, or any in IDLE, is dropped.
- A read issue and a data return in the same cycle leave outstanding unchanged. The FIFO supports a simultaneous push and pop.
- `m_last`=1 together with `m_valid` exactly on word index `word_count`−1. It is a tracked popped-word count, not FIFO state.
- Counters are ADD_SIZE+1 bits, so `word_count`=2^ADD_SIZE is legal and wraps the address space exactly once.

## Timing
- Reset values: `busy`=0, `done`=0, `mem_read_en`=0, `mem_read_address`=0, `mem_in_ready`=0, `m_valid`=0, `m_last`=0, `m_data`=0. FSM=IDLE; all counters and the FIFO are empty.
- Reset mid-transfer aborts immediately. In-flight returns arriving after reset release are dropped (state is IDLE).
- All outputs are registered.
- First `mem_read_en` is asserted the cycle after the `start` cycle. `busy` rises in the same cycle.
- `m_valid` rises one cycle after the first `mem_out_valid`.
- Sustained throughput is 1 word/cycle when `m_ready`=1 and wrapper read latency ≤ FIFO_DEPTH−1.
- `m_data`, `m_last`, and `m_valid` stay stable while `m_valid`=1 and `m_ready`=0.
- `done` is asserted the cycle after the final stream handshake.

## Structure
- Package `output_stream_pkg`:
  - `state_t` enum {IDLE, ISSUE, DRAIN, DONE}
  - default `FIFO_DEPTH`
  - `CNT_W` = ADD_SIZE+1 helper
- Sub-module `stream_fifo`: parameterised synchronous FIFO with count output and same-cycle push/pop. It uses the same `clk`/`rst` (async active-low) convention.

## Test plan
- `base_addr`=0x010, `word_count`=8, `m_ready`=1, wrapper latency 2 → addresses 0x010..0x017 in order; 8 words out with matching data; `m_last` on the 8th; `done` one cycle after.
- Same transfer with `m_ready` toggling 1/0 every cycle → no word lost or duplicated; outstanding + fifo_count never exceeds 4; `m_data` stable while stalled.
- `base_addr`=0x7FE, `word_count`=4 → addresses 0x7FE, 0x7FF, 0x000, 0x001.
- `word_count`=0 → no `mem_read_en`, no `m_valid`; `done` pulses the cycle after `start`.
- `start` re-asserted during ISSUE with different args → ignored; original transfer completes unchanged.
- `rst` low after 3 of 8 words, then spurious `mem_out_valid` after release → all outputs return to reset values; no stream output; next `start` runs cleanly.
